// File: rtl/warning_annunciator.sv
// Warning annunciator: time-shares one cluster display slot between active warnings
// and drives a single chime with a limited, acknowledgeable beep cadence.
module warning_annunciator #(
    parameter int         DWELL     = 8,
    parameter int         CHIME_ON  = 4,
    parameter int         CHIME_OFF = 4,
    parameter int         MAX_BEEPS = 3,
    parameter logic [6:0] PRI2_MASK = 7'b0001111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] warn_vec,
    input  logic       ack,
    output logic       disp_valid,
    output logic [2:0] disp_id,
    output logic       disp_pri2,
    output logic       chime,
    output logic       chime_muted
);

    localparam int TMAX_A = (DWELL > CHIME_ON) ? DWELL : CHIME_ON;
    localparam int TMAX   = (TMAX_A > CHIME_OFF) ? TMAX_A : CHIME_OFF;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int BW     = $clog2(MAX_BEEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_MUTED} chime_state_t;

    chime_state_t   state, state_d;
    logic [TW-1:0]  dwell_cnt, dwell_d, chime_tmr, chime_tmr_d;
    logic [BW-1:0]  beeps, beeps_d;
    logic [6:0]     prev_warn;
    logic [6:0]     pri2_act, pri1_act, act, rise;
    logic           want_pri2, valid_d, pri2_d;
    logic [2:0]     id_d;

    function automatic logic [2:0] lowest(input logic [6:0] v);
        lowest = '0;
        for (int i = 6; i >= 0; i--)
            if (v[3'(i)]) lowest = 3'(i);
    endfunction

    // Next active index strictly above cur, wrapping 6->0; returns cur if it is the only one.
    function automatic logic [2:0] next_above(input logic [6:0] v, input logic [2:0] cur);
        logic found;
        int   cand;
        next_above = cur;
        found      = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cand = (int'(cur) + k) % 7;
            if (!found && v[3'(cand)]) begin
                next_above = 3'(cand);
                found      = 1'b1;
            end
        end
    endfunction

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        pri2_act  = warn_vec & PRI2_MASK;
        pri1_act  = warn_vec & ~PRI2_MASK;
        want_pri2 = |pri2_act;
        act       = want_pri2 ? pri2_act : pri1_act;
        valid_d   = disp_valid;
        id_d      = disp_id;
        pri2_d    = disp_pri2;
        dwell_d   = dwell_cnt;
        if (act == '0) begin
            valid_d = 1'b0;
            id_d    = '0;
            pri2_d  = 1'b0;
            dwell_d = '0;
        end else if (!disp_valid || (disp_pri2 != want_pri2)) begin
            valid_d = 1'b1;
            pri2_d  = want_pri2;
            id_d    = lowest(act);
            dwell_d = TW'(DWELL);
        end else if (!act[disp_id] || (dwell_cnt <= TW'(1))) begin
            // A cleared bit and a dwell expiry both step forward; the cleared case needs no extra branch.
            id_d    = next_above(act, disp_id);
            dwell_d = TW'(DWELL);
        end else begin
            dwell_d = dwell_cnt - TW'(1);
        end
    end

    always_comb begin
        rise        = warn_vec & ~prev_warn & PRI2_MASK;
        state_d     = state;
        chime_tmr_d = chime_tmr;
        beeps_d     = beeps;
        if (!want_pri2) begin
            state_d     = S_IDLE;
            chime_tmr_d = '0;
            beeps_d     = '0;
        end else if (|rise) begin
            state_d     = S_ON;
            chime_tmr_d = TW'(CHIME_ON);
            beeps_d     = BW'(1);
        end else begin
            case (state)
                S_ON: begin
                    if (ack) begin
                        state_d     = S_MUTED;
                        chime_tmr_d = '0;
                    end else if (chime_tmr <= TW'(1)) begin
                        if (beeps >= BW'(MAX_BEEPS)) begin
                            state_d     = S_MUTED;
                            chime_tmr_d = '0;
                        end else begin
                            state_d     = S_OFF;
                            chime_tmr_d = TW'(CHIME_OFF);
                        end
                    end else begin
                        chime_tmr_d = chime_tmr - TW'(1);
                    end
                end
                S_OFF: begin
                    if (ack) begin
                        state_d     = S_MUTED;
                        chime_tmr_d = '0;
                    end else if (chime_tmr <= TW'(1)) begin
                        state_d     = S_ON;
                        chime_tmr_d = TW'(CHIME_ON);
                        if (beeps != '1) beeps_d = beeps + BW'(1);
                    end else begin
                        chime_tmr_d = chime_tmr - TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            chime_tmr   <= '0;
            beeps       <= '0;
            dwell_cnt   <= '0;
            prev_warn   <= '0;
            disp_valid  <= 1'b0;
            disp_id     <= '0;
            disp_pri2   <= 1'b0;
            chime       <= 1'b0;
            chime_muted <= 1'b0;
        end else begin
            state       <= state_d;
            chime_tmr   <= chime_tmr_d;
            beeps       <= beeps_d;
            dwell_cnt   <= dwell_d;
            prev_warn   <= warn_vec;
            disp_valid  <= valid_d;
            disp_id     <= id_d;
            disp_pri2   <= pri2_d;
            chime       <= (state_d == S_ON);
            chime_muted <= (state_d == S_MUTED);
        end
    end

endmodule

// File: tb/tb_warning_annunciator.sv
// Directed bench for warning_annunciator with short timing parameters
// (DWELL=4, CHIME_ON=2, CHIME_OFF=3, MAX_BEEPS=2).
module tb_warning_annunciator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] warn_vec;
    logic       ack;
    logic       disp_valid;
    logic [2:0] disp_id;
    logic       disp_pri2;
    logic       chime;
    logic       chime_muted;

    int errors = 0;
    int checks = 0;

    warning_annunciator #(
        .DWELL(4), .CHIME_ON(2), .CHIME_OFF(3), .MAX_BEEPS(2), .PRI2_MASK(7'b0001111)
    ) dut (
        .clk(clk), .rst_n(rst_n), .warn_vec(warn_vec), .ack(ack),
        .disp_valid(disp_valid), .disp_id(disp_id), .disp_pri2(disp_pri2),
        .chime(chime), .chime_muted(chime_muted)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {disp_valid, disp_id, disp_pri2, chime, chime_muted}
    function automatic logic [6:0] outs();
        return {disp_valid, disp_id, disp_pri2, chime, chime_muted};
    endfunction

    task automatic test_reset();
        logic [6:0] got;
        rst_n = 1'b0; warn_vec = 7'h7F; ack = 1'b0;
        step();
        got = outs();
        checks++;
        if (got !== 7'b0) begin
            $display("FAIL reset_outputs got=%b want=%b", got, 7'b0); errors++;
        end
        rst_n = 1'b1;
        step();
        got = outs();
        checks++;
        if (got !== {1'b1, 3'd0, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL reset_release got=%b want=%b", got, {1'b1, 3'd0, 1'b1, 1'b1, 1'b0}); errors++;
        end
        rst_n = 1'b0; warn_vec = 7'h00;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cadence();
        logic [9:0] exp_chime = 10'b1100011000;
        warn_vec = 7'b0000001;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (chime !== exp_chime[9 - i]) begin
                $display("FAIL cadence_chime[%0d] got=%b want=%b", i, chime, exp_chime[9 - i]); errors++;
            end
            checks++;
            if (disp_id !== 3'd0 || disp_valid !== 1'b1) begin
                $display("FAIL cadence_disp[%0d] got id=%0d valid=%b want id=0 valid=1", i, disp_id, disp_valid); errors++;
            end
        end
        checks++;
        if (chime_muted !== 1'b1) begin
            $display("FAIL cadence_muted got=%b want=1", chime_muted); errors++;
        end
        warn_vec = 7'b0;
        step();
        checks++;
        if (outs() !== 7'b0) begin
            $display("FAIL cadence_clear got=%b want=%b", outs(), 7'b0); errors++;
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_id;
        warn_vec = 7'b1010000;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_id = (i >= 4 && i < 8) ? 3'd6 : 3'd4;
            checks++;
            if (disp_id !== exp_id || disp_pri2 !== 1'b0 || chime !== 1'b0 || disp_valid !== 1'b1) begin
                $display("FAIL rotation[%0d] got id=%0d pri2=%b chime=%b valid=%b want id=%0d pri2=0 chime=0 valid=1",
                         i, disp_id, disp_pri2, chime, disp_valid, exp_id); errors++;
            end
        end
    endtask

    task automatic test_preempt();
        warn_vec = 7'b1010010;
        step();
        checks++;
        if (disp_id !== 3'd1 || disp_pri2 !== 1'b1 || chime !== 1'b1) begin
            $display("FAIL preempt_enter got id=%0d pri2=%b chime=%b want id=1 pri2=1 chime=1",
                     disp_id, disp_pri2, chime); errors++;
        end
        step();
        warn_vec = 7'b1010000;
        step();
        checks++;
        if (disp_id !== 3'd4 || disp_pri2 !== 1'b0 || chime !== 1'b0 || chime_muted !== 1'b0) begin
            $display("FAIL preempt_exit got id=%0d pri2=%b chime=%b muted=%b want id=4 pri2=0 chime=0 muted=0",
                     disp_id, disp_pri2, chime, chime_muted); errors++;
        end
    endtask

    task automatic test_ack_rearm();
        logic [6:0] exp_chime = 7'b1000110;
        warn_vec = 7'b0000001;
        step();
        checks++;
        if (chime !== 1'b1) begin
            $display("FAIL ack_start got chime=%b want 1", chime); errors++;
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (chime !== 1'b0 || chime_muted !== 1'b1) begin
            $display("FAIL ack_mute got chime=%b muted=%b want chime=0 muted=1", chime, chime_muted); errors++;
        end
        step(); step();
        checks++;
        if (chime !== 1'b0 || chime_muted !== 1'b1) begin
            $display("FAIL ack_hold got chime=%b muted=%b want chime=0 muted=1", chime, chime_muted); errors++;
        end
        // New rise together with ack: the rise restarts the episode.
        warn_vec = 7'b0000101; ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (chime !== 1'b1 || chime_muted !== 1'b0) begin
            $display("FAIL rearm_start got chime=%b muted=%b want chime=1 muted=0", chime, chime_muted); errors++;
        end
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (chime !== exp_chime[6 - i]) begin
                $display("FAIL rearm_chime[%0d] got=%b want=%b", i, chime, exp_chime[6 - i]); errors++;
            end
        end
        checks++;
        if (chime_muted !== 1'b1) begin
            $display("FAIL rearm_muted got=%b want=1", chime_muted); errors++;
        end
    endtask

    task automatic test_clear();
        warn_vec = 7'b0;
        step();
        warn_vec = 7'b0000110;
        step();
        checks++;
        if (disp_id !== 3'd1) begin
            $display("FAIL clear_enter got id=%0d want 1", disp_id); errors++;
        end
        step();
        warn_vec = 7'b0000100;
        step();
        checks++;
        if (disp_id !== 3'd2 || disp_valid !== 1'b1) begin
            $display("FAIL clear_step got id=%0d valid=%b want id=2 valid=1", disp_id, disp_valid); errors++;
        end
        warn_vec = 7'b0;
        step();
        checks++;
        if (disp_valid !== 1'b0 || disp_id !== 3'd0 || chime !== 1'b0) begin
            $display("FAIL clear_empty got valid=%b id=%0d chime=%b want 0 0 0", disp_valid, disp_id, chime); errors++;
        end
    endtask

    task automatic test_reset_mid();
        warn_vec = 7'b0000001;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (outs() !== 7'b0) begin
            $display("FAIL reset_mid got=%b want=%b", outs(), 7'b0); errors++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_rotation();
        test_preempt();
        test_ack_rearm();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
